prog_loader: RTL

Program loader that sits directly upstream of the Risc32 core's instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word-aligned instruction memory addresses. It holds the core in reset until the load completes, so test programs can be loaded by a bench or host link instead of being preinitialised in instruction memory.

---
 rtl/prog_loader.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Streams a program into the Risc32 instruction memory. Bytes arrive
// little-endian over a valid/ready handshake. Every four bytes form one
// 32-bit instruction word. Each word is written to the next word-aligned
// address, and the address wraps modulo ROW_I*4 bytes. The core is held in
// reset (cpu_rst = 1) until the load has finished.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra checksum byte is accepted after the last word.
//   The 8-bit sum of all data bytes plus the checksum byte must be 0x00.
//   Otherwise err is set. err stays set until the next start or rst.
//   When undefined, no checksum byte is expected and err is tied to 0.
//
// Parameters
//   ROW_I       instruction memory depth in words
//   CNT_W       width of word_count
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   start       one-cycle pulse that begins a load; word_count is latched
//   word_count  number of 32-bit words to load
//   byte_valid  upstream byte available
//   byte_data   upstream byte
//   byte_ready  loader accepts a byte this cycle (registered)
//   im_we       instruction memory write strobe (one cycle per word)
//   im_addr     word-aligned byte address of the current write
//   im_wdata    assembled instruction word
//   cpu_rst     hold-reset to the core, 1 while not done
//   busy        load in progress
//   done        load complete, core released
//   err         checksum mismatch (sticky)
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader #(
  parameter int ROW_I = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Width of the word index into instruction memory (at least one bit).
  localparam int WI_W = (ROW_I > 1) ? $clog2(ROW_I) : 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;     // words still to be written
  logic [1:0]       byte_idx_reg;  // lane of the next accepted byte
  logic [WI_W-1:0]  widx_reg;      // word index of the current write address
  logic [31:0]      word_reg;      // word under assembly

  logic             accept;
  logic [31:0]      word_next;
  logic [WI_W-1:0]  widx_next;

  // byte_ready is a register, so the handshake never loops back through
  // byte_valid combinationally.
  assign accept = byte_valid && byte_ready;

  // Lane steering: only the lane selected by byte_idx_reg takes the new byte.
  // The other lanes keep their previous contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (accept && (byte_idx_reg == 2'(gi)))
                                    ? byte_data
                                    : word_reg[8*gi +: 8];
    end
  endgenerate

  // The explicit wrap compare also handles depths that are not powers of two.
  assign widx_next = (widx_reg == WI_W'(ROW_I - 1)) ? '0 : widx_reg + WI_W'(1);

  // im_addr and im_wdata come straight from registers. The address therefore
  // shows the next free slot once the load has finished.
  assign im_addr  = {{(30 - WI_W){1'b0}}, widx_reg, 2'b00};
  assign im_wdata = word_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;  // running 8-bit sum of the data bytes
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      byte_idx_reg <= '0;
      widx_reg     <= '0;
      word_reg     <= '0;
      byte_ready   <= 1'b0;
      im_we        <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg      <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // The write strobe lasts a single cycle.
      im_we <= 1'b0;

      case (state_reg)
        // IDLE and DONE both accept a new start. A start in DONE puts the
        // core back into reset on the same edge.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_reg    <= word_count;
            byte_idx_reg <= '0;
            widx_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= '0;
            err          <= 1'b0;
`endif
            if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              // No data words, but the checksum byte is still expected.
              state_reg  <= ST_CHECK;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              cpu_rst    <= 1'b1;
`else
              state_reg  <= ST_DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_rst    <= 1'b0;
`endif
            end else begin
              state_reg  <= ST_RECV;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              cpu_rst    <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (accept) begin
            word_reg     <= word_next;
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= sum_reg + byte_data;
`endif
            if (byte_idx_reg == 2'd3) begin
              // The word is complete. Stop taking bytes and write it
              // during the following cycle.
              state_reg  <= ST_WRITE;
              byte_ready <= 1'b0;
              im_we      <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          widx_reg  <= widx_next;
          count_reg <= count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg  <= ST_CHECK;
            byte_ready <= 1'b1;
`else
            state_reg  <= ST_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_rst    <= 1'b0;
`endif
          end else begin
            state_reg  <= ST_RECV;
            byte_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            // The core is released whatever the checksum result is.
            // err only reports the mismatch.
            err        <= ((sum_reg + byte_data) != 8'd0);
            state_reg  <= ST_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_rst    <= 1'b0;
          end
        end
`endif

        default: begin
          state_reg  <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          cpu_rst    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
